// File: rtl/decode_stage_piped.sv
// decode_stage_piped: pipelined MIPS/DLX instruction-decode stage.
// Holds the 32-entry register file (with write-through bypass), the control
// decoder, the sign extender, the branch comparator and target adder, and
// load-use / branch-source hazard detection. It also holds the registered
// ID/EX boundary.
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   if_valid/if_instr/if_pc    : IF/ID contents
//   wb_we/wb_rw/wb_data        : register-file write port from WB
//   exmem_regwrite/exmem_rw    : EX/MEM destination, for branch-source hazards
//   stall/pc_sel/branch_target : same-cycle feedback to IF
//   id_ex_*                    : registered ID/EX pipeline outputs
module decode_stage_piped #(
  parameter int XLEN = 32,
  parameter int PC_W = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  input  logic            wb_we,
  input  logic [4:0]      wb_rw,
  input  logic [XLEN-1:0] wb_data,
  input  logic            exmem_regwrite,
  input  logic [4:0]      exmem_rw,
  output logic            stall,
  output logic            pc_sel,
  output logic [PC_W-1:0] branch_target,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_bus_a,
  output logic [XLEN-1:0] id_ex_bus_b,
  output logic [XLEN-1:0] id_ex_immed,
  output logic [4:0]      id_ex_rs,
  output logic [4:0]      id_ex_rt,
  output logic [4:0]      id_ex_rd,
  output logic [3:0]      id_ex_ex_ctrl,
  output logic [1:0]      id_ex_m_ctrl,
  output logic [1:0]      id_ex_wb_ctrl
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [XLEN-1:0] rf_q [32];

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] bus_a, bus_b, immed;
  logic [3:0]      ex_ctrl;
  logic [1:0]      m_ctrl, wb_ctrl;
  logic            is_br, is_j;
  logic            load_use, idex_hit, mem_hit, resolve;
  logic [4:0]      idex_dst;

  logic            valid_d, valid_q;
  logic [XLEN-1:0] bus_a_d, bus_a_q, bus_b_d, bus_b_q, immed_d, immed_q;
  logic [4:0]      rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [3:0]      ex_d, ex_q;
  logic [1:0]      m_d, m_q, wb_d, wb_q;

  assign opcode = if_instr[31:26];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];
  assign immed  = XLEN'($signed(if_instr[15:0]));

  // Register file; r0 is never written so it always reads 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_rw != 5'd0) begin
      rf_q[wb_rw] <= wb_data;
    end
  end

  // Write-through: a same-cycle WB write to a source is seen by the read.
  assign bus_a = (rs == 5'd0) ? '0 : (wb_we && wb_rw == rs) ? wb_data : rf_q[rs];
  assign bus_b = (rt == 5'd0) ? '0 : (wb_we && wb_rw == rt) ? wb_data : rf_q[rt];

  always_comb begin
    ex_ctrl = '0;
    m_ctrl  = '0;
    wb_ctrl = '0;
    case (opcode)
      OP_R:           begin ex_ctrl = 4'b1010; wb_ctrl = 2'b10; end
      OP_LW:          begin ex_ctrl = 4'b0100; m_ctrl = 2'b10; wb_ctrl = 2'b11; end
      OP_SW:          begin ex_ctrl = 4'b0100; m_ctrl = 2'b01; end
      OP_ADDI:        begin ex_ctrl = 4'b0100; wb_ctrl = 2'b10; end
      OP_BEQ, OP_BNE: ex_ctrl = 4'b0001;
      default:        ;
    endcase
  end

  assign is_br = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_j  = (opcode == OP_J);

  assign load_use = valid_q && m_q[1] && rt_q != 5'd0 && (rt_q == rs || rt_q == rt);

  // ID/EX destination is rd for R-type (reg_dst), otherwise rt.
  assign idex_dst = ex_q[3] ? rd_q : rt_q;
  assign idex_hit = valid_q && wb_q[1] &&
                    ((rs != 5'd0 && rs == idex_dst) || (rt != 5'd0 && rt == idex_dst));
  assign mem_hit  = exmem_regwrite &&
                    ((rs != 5'd0 && rs == exmem_rw) || (rt != 5'd0 && rt == exmem_rw));

  assign stall   = if_valid && (load_use || (is_br && (idex_hit || mem_hit)));
  assign resolve = if_valid && !stall;

  always_comb begin
    pc_sel        = 1'b0;
    branch_target = '0;
    if (resolve) begin
      if (is_br) begin
        branch_target = if_pc + immed[PC_W-1:0];
        pc_sel = (opcode == OP_BEQ) ? (bus_a == bus_b) : (bus_a != bus_b);
      end else if (is_j) begin
        branch_target = if_instr[PC_W-1:0];
        pc_sel        = 1'b1;
      end
    end
  end

  // A stalled or empty slot enters ID/EX as an all-zero bubble.
  always_comb begin
    valid_d = 1'b0;
    bus_a_d = '0;
    bus_b_d = '0;
    immed_d = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    ex_d    = '0;
    m_d     = '0;
    wb_d    = '0;
    if (resolve) begin
      valid_d = 1'b1;
      bus_a_d = bus_a;
      bus_b_d = bus_b;
      immed_d = immed;
      rs_d    = rs;
      rt_d    = rt;
      rd_d    = rd;
      ex_d    = ex_ctrl;
      m_d     = m_ctrl;
      wb_d    = wb_ctrl;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      bus_a_q <= '0;
      bus_b_q <= '0;
      immed_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ex_q    <= '0;
      m_q     <= '0;
      wb_q    <= '0;
    end else begin
      valid_q <= valid_d;
      bus_a_q <= bus_a_d;
      bus_b_q <= bus_b_d;
      immed_q <= immed_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ex_q    <= ex_d;
      m_q     <= m_d;
      wb_q    <= wb_d;
    end
  end

  assign id_ex_valid   = valid_q;
  assign id_ex_bus_a   = bus_a_q;
  assign id_ex_bus_b   = bus_b_q;
  assign id_ex_immed   = immed_q;
  assign id_ex_rs      = rs_q;
  assign id_ex_rt      = rt_q;
  assign id_ex_rd      = rd_q;
  assign id_ex_ex_ctrl = ex_q;
  assign id_ex_m_ctrl  = m_q;
  assign id_ex_wb_ctrl = wb_q;

endmodule

// File: doc/decode_stage_piped.md
Name: decode_stage_piped

Overview:
Parametrised pipelined MIPS/DLX instruction-decode stage. It contains:
- a 32-entry register file with write-through bypass;
- the main control decoder;
- sign extension;
- the branch comparator and branch-target adder;
- load-use and branch-source hazard detection;
- the registered ID/EX pipeline boundary.

It sits between the IF/ID register and the EX stage. It drives pc_sel, branch_target and stall back to IF.

Parameters:
XLEN, 32, datapath/register width (>=16)
PC_W, 10, program-counter width in words (<=16)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
if_valid  in  1  IF/ID holds a real instruction
if_instr  in  32  instruction word
if_pc  in  PC_W  PC of if_instr
wb_we  in  1  write-back register write enable
wb_rw  in  5  write-back destination
wb_data  in  XLEN  write-back data
exmem_regwrite  in  1  EX/MEM instruction writes a register
exmem_rw  in  5  EX/MEM destination
stall  out  1  hold PC and IF/ID this cycle (combinational)
pc_sel  out  1  take branch_target (combinational)
branch_target  out  PC_W  redirect address
id_ex_valid  out  1  registered
id_ex_bus_a, id_ex_bus_b  out  XLEN  registered operands
id_ex_immed  out  XLEN  registered sign-extended immediate
id_ex_rs, id_ex_rt, id_ex_rd  out  5  registered instr[25:21], [20:16], [15:11]
id_ex_ex_ctrl  out  4  {reg_dst, alu_src, alu_op[1:0]}
id_ex_m_ctrl  out  2  {mem_read, mem_write}
id_ex_wb_ctrl  out  2  {reg_write, mem_to_reg}

Behaviour:
Clock and reset: one clock domain, clock; reset is synchronous and active-high.

Register file:
- reset clears all 32 entries to 0.
- write on the clock edge when wb_we=1 and wb_rw!=0; r0 always reads 0.
- reads are combinational with write-through: if wb_we & wb_rw==src & src!=0, the read returns wb_data.

Immediate: immed = sign-extend instr[15:0] to XLEN.

Decode, by opcode instr[31:26]; fields given as ex/m/wb:
- 000000 R-type: 1010 / 00 / 10
- 100011 LW: 0100 / 10 / 11
- 101011 SW: 0100 / 01 / 00
- 001000 ADDI: 0100 / 00 / 10
- 000100 BEQ and 000101 BNE: 0001 / 00 / 00
- 000010 J: all zero
- any other opcode: all zero (NOP)

Hazards (stall is forced to 0 when if_valid=0):
- Load-use: stall=1 when id_ex_valid & id_ex_m_ctrl[1] & id_ex_rt!=0 & (id_ex_rt==rs | id_ex_rt==rt).
- Branch source: for BEQ/BNE only, stall=1 when a source register (rs or rt, nonzero) matches either:
  - id_ex_rd (if id_ex_ex_ctrl[3]) or id_ex_rt (if not), with id_ex_valid & id_ex_wb_ctrl[1]; or
  - exmem_rw, with exmem_regwrite.
- Consequence: an ALU-to-branch dependency stalls 2 cycles; a load-to-branch dependency stalls 2 cycles (the WB stage is covered by write-through).

Branch resolution (combinational, evaluated only when if_valid & !stall):
- pc_sel=1 for BEQ with bus_a==bus_b, for BNE with bus_a!=bus_b, and for J.
- branch_target is if_pc + immed[PC_W-1:0], mod 2^PC_W, for BEQ/BNE; it is instr[PC_W-1:0] for J.
- In every other case pc_sel=0 and branch_target=0.
- IF squashes its fetched instruction itself when pc_sel=1.

ID/EX register, updated on each rising edge:
- reset: all outputs 0, id_ex_valid=0.
- stall or !if_valid: bubble. id_ex_valid=0 and all ctrl/data fields are 0.
- otherwise: load the decoded fields with id_ex_valid=1. A taken branch itself enters as valid with zero writes.
- Reset asserted mid-stall clears the pipeline and stall deasserts next cycle. Register-file writes in the reset cycle are discarded.

Latency: 1 cycle from IF/ID to ID/EX. stall and pc_sel are same-cycle.

Test Plan:
1. Reset, then R-type add r3,r1,r2 with r1=5, r2=7 preloaded via WB -> next cycle id_ex_valid=1, bus_a=5, bus_b=7, rd=3, ex=1010, wb=10.
2. Write-through: wb_we=1, wb_rw=4, wb_data=0xDEAD in the same cycle ID reads r4 -> id_ex_bus_a=0xDEAD; a write to r0 -> r0 still reads 0.
3. LW r2,0(r1) followed by ADD r5,r2,r2 -> stall=1 for exactly 1 cycle, one bubble (valid=0, ctrl 0), then the ADD loads.
4. BEQ r1,r1,+8 at if_pc=20, no hazards -> pc_sel=1, branch_target=28. BNE with equal operands -> pc_sel=0. J at target 0x3FF with PC_W=10 -> target 0x3FF.
5. ADDI r1 followed by BEQ r1,r0 -> stall 2 cycles (ID/EX then EX/MEM match via exmem_regwrite), pc_sel=0 while stalled, then the branch resolves.
6. Wrap and reset: if_pc=1020, immed=+8, PC_W=10 -> target 4. Reset asserted during a stall -> next cycle all id_ex outputs 0 and stall=0.
